fir_mac_sequencer: RTL and testbench
====================================

Name: fir_mac_sequencer

Overview:
Control FSM for a single-MAC, time-multiplexed decimating FIR filter.
- Pops input samples from the x FIFO and writes them into an external TAPS-deep circular sample buffer.
- For every DECIMATION samples, sequences TAPS multiply-accumulate cycles over the external sample buffer and coefficient ROM.
- Pushes the result into the y FIFO.
- Sits between the input/output FIFOs of the FIR top level and the shared MAC datapath.

Parameters:
TAPS, 32, filter length; must be a power of 2, >= 2.
DECIMATION, 8, input samples consumed per output; 1 <= DECIMATION <= TAPS.
DATA_SIZE, 32, sample/result width.
MAC_LATENCY, 2, cycles from last mac_en to valid mac_acc; >= 1.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
x_in  in  DATA_SIZE  x FIFO head word; valid whenever x_empty=0
x_empty  in  1  x FIFO empty
x_rd_en  out  1  pop x FIFO this cycle
buf_wr_en  out  1  sample buffer write strobe
buf_wr_addr  out  AW  write address; AW = $clog2(TAPS)
buf_wr_data  out  DATA_SIZE  write data
buf_rd_addr  out  AW  sample buffer read address (to MAC)
coef_addr  out  AW  coefficient ROM address (to MAC)
mac_clr  out  1  MAC loads product instead of accumulating
mac_en  out  1  MAC operand pair valid this cycle
mac_acc  in  DATA_SIZE  MAC accumulator result (already scaled)
y_out_full  in  1  y FIFO full
y_wr_en  out  1  push y FIFO this cycle
y_out  out  DATA_SIZE  registered result to y FIFO

Behaviour:
- Reset:
  - State = CLEAR; head = 0; sample count = 0; tap count = 0.
  - y_out = 0. All strobes 0. All addresses 0.
  - Reset asserted in any state aborts the current operation; the next cycle behaves as reset.
- CLEAR:
  - Runs for TAPS cycles: buf_wr_en = 1, buf_wr_addr = 0..TAPS-1, buf_wr_data = 0.
  - x_rd_en = 0 throughout. Then go to FILL.
- FILL:
  - x_rd_en = !x_empty (combinational).
  - On a pop, in the same cycle: buf_wr_en = 1, buf_wr_addr = head, buf_wr_data = x_in.
  - head <= head+1 mod TAPS; count++.
  - Bubbles (x_empty=1) stall without state change.
  - After the DECIMATION-th pop, count resets to 0 and the FSM goes to MAC.
- MAC:
  - Runs exactly TAPS cycles, k = 0..TAPS-1.
  - mac_en = 1; coef_addr = k; buf_rd_addr = (head-1-k) mod TAPS, so the newest sample pairs with coef 0.
  - mac_clr = 1 only at k = 0.
  - x_rd_en = 0. Then go to WAIT.
- WAIT:
  - Runs MAC_LATENCY cycles with mac_en = 0.
  - On the final WAIT cycle edge, y_out <= mac_acc. Then go to WRITE.
- WRITE:
  - y_wr_en = !y_out_full.
  - y_out holds stable while stalled.
  - On the push, go to FILL.
- Latency: last pop in cycle N gives y_wr_en in cycle N+TAPS+MAC_LATENCY+1 when y_out_full = 0.
- Throughput: no input is consumed outside FILL. Input backpressure propagates via the x FIFO.
- Address arithmetic: wraps naturally in AW bits; no overflow checks are needed.
- mac_en, mac_clr and buf_wr_en are never asserted in WRITE or WAIT.

Decomposition:
- Package fir_pkg holds:
  - state enum {CLEAR, FILL, MAC, WAIT, WRITE};
  - AW localparam helper;
  - default TAPS/DECIMATION constants shared with the FIR top level.
- No sub-module. Head, sample, tap and wait counters live in one FSM file. Target 150-250 lines.

Test Plan:
(All scenarios use TAPS=4, DECIMATION=2, MAC_LATENCY=2; the bench MAC model returns mac_acc = 0x55.)
1. Reset release -> 4 cycles of buf_wr_en=1 at addresses 0,1,2,3 with data 0; x_rd_en=0 during them even with x_empty=0.
2. Push 0x1, 0x2 back-to-back -> writes addr0=0x1, addr1=0x2; MAC cycles buf_rd_addr 1,0,3,2 with coef_addr 0,1,2,3; mac_clr only on the first; y_wr_en in cycle N+7 with y_out=0x55.
3. Hold y_out_full=1 for 10 cycles at WRITE -> y_wr_en=0 and y_out=0x55 stable; x_rd_en=0; exactly one push after full drops.
4. Input with x_empty toggling every cycle -> pops only on empty=0; MAC starts 1 cycle after the 2nd pop; no duplicate or dropped writes.
5. Three consecutive blocks (samples 1..6) -> samples 5,6 land at addr 0,1 (wrap); third MAC reads addresses 1,0,3,2.
6. Reset asserted at MAC k=2 -> next cycle all strobes 0 and y_out=0; CLEAR repeats its 4 cycles; no y_wr_en for the aborted block.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and constants for the decimating FIR control path.
package fir_pkg;

  localparam int unsigned FIR_TAPS        = 32;
  localparam int unsigned FIR_DECIMATION  = 8;
  localparam int unsigned FIR_DATA_SIZE   = 32;
  localparam int unsigned FIR_MAC_LATENCY = 2;

  typedef enum logic [2:0] {
    CLEAR,
    FILL,
    MAC,
    WAIT,
    WRITE
  } fir_state_e;

  // Address width for a power-of-2 deep buffer; never narrower than one bit.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fir_mac_sequencer.sv
// Sequencer for a single-MAC decimating FIR: clears the sample buffer,
// gathers DECIMATION samples, runs TAPS MAC beats, then emits one result.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int unsigned TAPS        = FIR_TAPS,
  parameter int unsigned DECIMATION  = FIR_DECIMATION,
  parameter int unsigned DATA_SIZE   = FIR_DATA_SIZE,
  parameter int unsigned MAC_LATENCY = FIR_MAC_LATENCY,
  localparam int unsigned AW         = addr_width(TAPS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] x_in,
  input  logic                 x_empty,
  output logic                 x_rd_en,
  output logic                 buf_wr_en,
  output logic [AW-1:0]        buf_wr_addr,
  output logic [DATA_SIZE-1:0] buf_wr_data,
  output logic [AW-1:0]        buf_rd_addr,
  output logic [AW-1:0]        coef_addr,
  output logic                 mac_clr,
  output logic                 mac_en,
  input  logic [DATA_SIZE-1:0] mac_acc,
  input  logic                 y_out_full,
  output logic                 y_wr_en,
  output logic [DATA_SIZE-1:0] y_out
);

  localparam int unsigned WW = addr_width(MAC_LATENCY + 1);

  localparam logic [AW-1:0] LAST_TAP    = AW'(TAPS - 1);
  localparam logic [AW-1:0] LAST_SAMPLE = AW'(DECIMATION - 1);
  localparam logic [WW-1:0] LAST_WAIT   = WW'(MAC_LATENCY - 1);

  fir_state_e    state;
  logic [AW-1:0] head;
  logic [AW-1:0] sample_cnt;
  logic [AW-1:0] tap_cnt;
  logic [WW-1:0] wait_cnt;

  // State, counters and the result register; tap_cnt doubles as the CLEAR address.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= CLEAR;
      head       <= '0;
      sample_cnt <= '0;
      tap_cnt    <= '0;
      wait_cnt   <= '0;
      y_out      <= '0;
    end else begin
      case (state)
        CLEAR: begin
          if (tap_cnt == LAST_TAP) begin
            tap_cnt <= '0;
            state   <= FILL;
          end else begin
            tap_cnt <= tap_cnt + AW'(1);
          end
        end
        FILL: begin
          if (!x_empty) begin
            head <= head + AW'(1);
            if (sample_cnt == LAST_SAMPLE) begin
              sample_cnt <= '0;
              state      <= MAC;
            end else begin
              sample_cnt <= sample_cnt + AW'(1);
            end
          end
        end
        MAC: begin
          if (tap_cnt == LAST_TAP) begin
            tap_cnt <= '0;
            state   <= WAIT;
          end else begin
            tap_cnt <= tap_cnt + AW'(1);
          end
        end
        WAIT: begin
          if (wait_cnt == LAST_WAIT) begin
            wait_cnt <= '0;
            y_out    <= mac_acc;
            state    <= WRITE;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        WRITE: begin
          if (!y_out_full) begin
            state <= FILL;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Strobes and addresses decoded from registered state; quiet while reset is high.
  always_comb begin
    x_rd_en     = 1'b0;
    buf_wr_en   = 1'b0;
    buf_wr_addr = '0;
    buf_wr_data = '0;
    buf_rd_addr = '0;
    coef_addr   = '0;
    mac_clr     = 1'b0;
    mac_en      = 1'b0;
    y_wr_en     = 1'b0;
    if (!reset) begin
      case (state)
        CLEAR: begin
          buf_wr_en   = 1'b1;
          buf_wr_addr = tap_cnt;
        end
        FILL: begin
          x_rd_en     = !x_empty;
          buf_wr_en   = !x_empty;
          buf_wr_addr = head;
          buf_wr_data = x_in;
        end
        MAC: begin
          mac_en      = 1'b1;
          mac_clr     = (tap_cnt == '0);
          coef_addr   = tap_cnt;
          // Newest sample (head-1) pairs with coefficient 0.
          buf_rd_addr = head - AW'(1) - tap_cnt;
        end
        WRITE: begin
          y_wr_en = !y_out_full;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Randomized scoreboard bench for fir_mac_sequencer with an FIR reference model.
module tb_fir_mac_sequencer;

  localparam int unsigned TAPS = 4;
  localparam int unsigned DEC  = 2;
  localparam int unsigned DW   = 32;
  localparam int unsigned ML   = 2;
  localparam int unsigned AW   = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] x_in;
  logic          x_empty;
  logic          x_rd_en;
  logic          buf_wr_en;
  logic [AW-1:0] buf_wr_addr;
  logic [DW-1:0] buf_wr_data;
  logic [AW-1:0] buf_rd_addr;
  logic [AW-1:0] coef_addr;
  logic          mac_clr;
  logic          mac_en;
  logic [DW-1:0] mac_acc;
  logic          y_out_full;
  logic          y_wr_en;
  logic [DW-1:0] y_out;

  always #5 clock = ~clock;

  fir_mac_sequencer #(
    .TAPS(TAPS), .DECIMATION(DEC), .DATA_SIZE(DW), .MAC_LATENCY(ML)
  ) dut (
    .clock(clock), .reset(reset), .x_in(x_in), .x_empty(x_empty), .x_rd_en(x_rd_en),
    .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .buf_rd_addr(buf_rd_addr), .coef_addr(coef_addr), .mac_clr(mac_clr), .mac_en(mac_en),
    .mac_acc(mac_acc), .y_out_full(y_out_full), .y_wr_en(y_wr_en), .y_out(y_out)
  );

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; bit clr; } wr_t;
  typedef struct { logic [AW-1:0] rd; logic [AW-1:0] coef; bit clr; } mac_t;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  logic [DW-1:0] xq[$];
  logic [DW-1:0] hist[$];
  wr_t           exp_wr[$];
  mac_t          exp_mac[$];
  logic [DW-1:0] exp_y[$];

  int x_mode    = 0;  // 0 steady, 1 toggling bubbles, 2 random bubbles
  int full_mode = 0;  // 0 never full, 1 held full, 2 random full
  bit pop_pending = 1'b0;
  bit tog = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Environment: external sample buffer, coefficient ROM and a MAC with 2-cycle result latency.
  logic [DW-1:0] buf_mem  [TAPS];
  logic [DW-1:0] coef_rom [TAPS];
  logic [DW-1:0] acc_q, acc_d1;
  logic [DW-1:0] prod;
  assign prod    = buf_mem[buf_rd_addr] * coef_rom[coef_addr];
  assign mac_acc = acc_d1;

  always @(posedge clock) begin
    if (buf_wr_en) buf_mem[buf_wr_addr] <= buf_wr_data;
    if (mac_en) acc_q <= mac_clr ? prod : acc_q + prod;
    acc_d1 <= acc_q;
  end

  // Reference: push sample, expected buffer write and, per block, MAC beats and FIR output.
  task automatic enqueue(input logic [DW-1:0] v);
    int n;
    logic [DW-1:0] acc;
    xq.push_back(v);
    hist.push_back(v);
    n = hist.size();
    exp_wr.push_back('{addr: AW'(n - 1), data: v, clr: 1'b0});
    if (n % DEC == 0) begin
      acc = '0;
      for (int k = 0; k < TAPS; k++) begin
        exp_mac.push_back('{rd: AW'(n - 1 - k), coef: AW'(k), clr: (k == 0)});
        if (n - 1 - k >= 0) acc = acc + coef_rom[k] * hist[n - 1 - k];
      end
      exp_y.push_back(acc);
    end
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    xq.delete(); hist.delete(); exp_wr.delete(); exp_mac.delete(); exp_y.delete();
    repeat (n) @(posedge clock);
    #1 reset = 1'b0;
    for (int k = 0; k < TAPS; k++) exp_wr.push_back('{addr: AW'(k), data: '0, clr: 1'b1});
  endtask

  task automatic wait_drain(input int budget, input string name);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clock); #1;
      done = (xq.size() == 0 && exp_wr.size() == 0 && exp_mac.size() == 0 && exp_y.size() == 0);
    end
    chk(name, 32'(done), 32'd1);
  endtask

  // Input FIFO / output FIFO drivers.
  initial begin
    bit bubble;
    x_empty = 1'b1; x_in = '0; y_out_full = 1'b0;
    forever begin
      @(posedge clock); #2;
      if (pop_pending && xq.size() != 0) void'(xq.pop_front());
      tog = !tog;
      case (x_mode)
        0:       bubble = 1'b0;
        1:       bubble = tog;
        default: bubble = ($urandom_range(0, 1) == 1);
      endcase
      x_empty = (xq.size() == 0) || bubble;
      x_in    = (xq.size() != 0) ? xq[0] : DW'($urandom);
      case (full_mode)
        0:       y_out_full = 1'b0;
        1:       y_out_full = 1'b1;
        default: y_out_full = ($urandom_range(0, 3) == 0);
      endcase
    end
  end

  // Monitor: compares every DUT strobe against the scoreboard queues.
  bit  rst_prev = 1'b0;
  bit  full_hist[int];
  int  lat_q[$];
  int  pop_cnt = 0;
  int  last_blk_pop = -100;

  always @(negedge clock) begin
    wr_t  w;
    mac_t m;
    int   lp, earliest;
    bit   ok;
    cyc++;
    full_hist[cyc] = y_out_full;
    pop_pending = x_rd_en;
    if (reset) begin
      chk("rst_strobes", 32'({x_rd_en, buf_wr_en, mac_en, mac_clr, y_wr_en}), 32'd0);
      chk("rst_addrs", 32'({buf_wr_addr, buf_rd_addr, coef_addr}), 32'd0);
      if (rst_prev) chk("rst_y_out", y_out, 32'd0);
      pop_cnt = 0; lat_q.delete(); last_blk_pop = -100;
    end else begin
      if (x_rd_en) begin
        chk("pop_nonempty", 32'(x_empty), 32'd0);
        chk("pop_has_write", 32'(buf_wr_en), 32'd1);
        pop_cnt++;
        if (pop_cnt % DEC == 0) begin
          lat_q.push_back(cyc);
          last_blk_pop = cyc;
        end
      end
      if (buf_wr_en) begin
        chk("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
        if (exp_wr.size() != 0) begin
          w = exp_wr.pop_front();
          chk("wr_addr", 32'(buf_wr_addr), 32'(w.addr));
          chk("wr_data", buf_wr_data, w.data);
          chk("wr_pop", 32'(x_rd_en), 32'(!w.clr));
        end
      end
      if (mac_en) begin
        chk("mac_exclusive", 32'({buf_wr_en, x_rd_en, y_wr_en}), 32'd0);
        chk("mac_expected", 32'(exp_mac.size() != 0), 32'd1);
        if (exp_mac.size() != 0) begin
          m = exp_mac.pop_front();
          chk("mac_rd_addr", 32'(buf_rd_addr), 32'(m.rd));
          chk("mac_coef_addr", 32'(coef_addr), 32'(m.coef));
          chk("mac_clr", 32'(mac_clr), 32'(m.clr));
          if (m.clr) chk("mac_start", 32'(cyc), 32'(last_blk_pop + 1));
        end
      end else if (mac_clr) begin
        chk("clr_without_en", 32'(mac_clr), 32'd0);
      end
      if (y_wr_en) begin
        chk("y_not_full", 32'(y_out_full), 32'd0);
        chk("y_expected", 32'(exp_y.size() != 0), 32'd1);
        if (exp_y.size() != 0) chk("y_out", y_out, exp_y.pop_front());
        chk("y_block_known", 32'(lat_q.size() != 0), 32'd1);
        if (lat_q.size() != 0) begin
          lp = lat_q.pop_front();
          earliest = lp + TAPS + ML + 1;
          ok = (cyc >= earliest);
          for (int c = earliest; c < cyc; c++) if (!full_hist[c]) ok = 1'b0;
          chk("y_latency", 32'(ok), 32'd1);
        end
      end
    end
    rst_prev = reset;
  end

  // Stimulus sequence.
  initial begin
    bit found;
    reset = 1'b1;
    for (int k = 0; k < TAPS; k++) begin
      coef_rom[k] = DW'($urandom);
      buf_mem[k]  = '0;
    end
    acc_q = '0; acc_d1 = '0;
    #1;
    apply_reset(3);

    // Clear pass with input already waiting, then a first block.
    enqueue(32'h1); enqueue(32'h2);
    wait_drain(100, "drain_first_block");

    // Output held full well past the block completion.
    full_mode = 1;
    enqueue(32'h3); enqueue(32'h4);
    repeat (25) @(posedge clock);
    #1;
    chk("stall_no_push", 32'(exp_y.size()), 32'd1);
    if (exp_y.size() != 0) chk("stall_y_out", y_out, exp_y[0]);
    chk("stall_no_pop", 32'(x_rd_en), 32'd0);
    full_mode = 0;
    wait_drain(100, "drain_after_stall");

    // Toggling input bubbles; samples 5,6 wrap to buffer addresses 0,1.
    x_mode = 1;
    for (int i = 5; i <= 8; i++) enqueue(DW'(i));
    wait_drain(200, "drain_toggle");

    // Random data, bubbles and output backpressure.
    x_mode = 2; full_mode = 2;
    for (int i = 0; i < 40; i++) enqueue(DW'($urandom));
    wait_drain(3000, "drain_random");

    // Reset in the middle of a MAC pass, then recover.
    x_mode = 0; full_mode = 0;
    enqueue(DW'($urandom)); enqueue(DW'($urandom));
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clock); #1;
      found = mac_en && (coef_addr == AW'(2));
    end
    chk("reach_mac_k2", 32'(found), 32'd1);
    apply_reset(2);
    enqueue(DW'($urandom)); enqueue(DW'($urandom));
    enqueue(DW'($urandom)); enqueue(DW'($urandom));
    wait_drain(200, "drain_after_reset");

    repeat (5) @(posedge clock);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

endmodule
